// File: rtl/rb_pkg.sv
// Shared types and helpers for the transactional ring buffer: decoded control strobe and
// modular pointer distance.
package rb_pkg;

  typedef enum logic [1:0] {
    RB_NONE,
    RB_OPEN,
    RB_COMMIT,
    RB_ROLLBACK
  } rb_ctrl_e;

  // Distance a-b on pointers that wrap modulo 2**ptrw.
  function automatic int unsigned rb_dist(int unsigned a, int unsigned b, int unsigned ptrw);
    return (a - b) & ((32'd1 << ptrw) - 32'd1);
  endfunction

  // Rollback beats commit beats open; losers in the same cycle are ignored.
  function automatic rb_ctrl_e rb_decode(logic open, logic commit, logic rollback);
    if (rollback) return RB_ROLLBACK;
    if (commit)   return RB_COMMIT;
    if (open)     return RB_OPEN;
    return RB_NONE;
  endfunction

endpackage

// File: rtl/rb_dpram.sv
// Register-array storage: one write port, one registered read port that holds its value
// when not enabled. No reset on contents.
module rb_dpram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DATAW = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATAW-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATAW-1:0]         rdata_o
);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [DATAW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/transactional_ring_buffer.sv
// Ring buffer whose writes land in a tentative region and only become poppable on commit;
// rollback/open discard the tentative region.
`ifndef DATAW_TOP
`define DATAW_TOP 15
`endif

module transactional_ring_buffer
  import rb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DATAW = `DATAW_TOP + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_request,
  input  logic [DATAW-1:0]       push_data,
  output logic                   push_done,
  output logic                   push_overflow,
  input  logic                   pop_request,
  output logic [DATAW-1:0]       pop_data,
  output logic                   pop_done,
  output logic                   pop_underflow,
  input  logic                   rb_open,
  input  logic                   rb_commit,
  input  logic                   rb_rollback,
  output logic [$clog2(DEPTH):0] used_count,
  output logic [$clog2(DEPTH):0] pending_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PTRW = AW + 1;
  typedef logic [PTRW-1:0] rb_ptr_t;

  rb_ptr_t  rd_q, rd_d, wc_q, wc_d, wt_q, wt_d, wt_base;
  rb_ptr_t  used_q, used_d, pend_q, pend_d;
  rb_ctrl_e ctrl;
  logic     full, empty, push_ok, pop_ok;
  logic     push_done_q, push_ovf_q, pop_done_q, pop_unf_q, data_vld_q;
  logic [DATAW-1:0] ram_rdata;

  always_comb begin
    ctrl    = rb_decode(rb_open, rb_commit, rb_rollback);
    wt_base = (ctrl == RB_OPEN || ctrl == RB_ROLLBACK) ? wc_q : wt_q;
    wc_d    = (ctrl == RB_COMMIT) ? wt_q : wc_q;
    // Fullness uses pre-edge rd: a concurrent pop does not make room this cycle.
    full    = rb_dist(32'(wt_base), 32'(rd_q), PTRW) == DEPTH;
    push_ok = push_request && !full;
    wt_d    = wt_base + rb_ptr_t'(push_ok);
    empty   = (rd_q == wc_q);
    pop_ok  = pop_request && !empty;
    rd_d    = rd_q + rb_ptr_t'(pop_ok);
    used_d  = rb_ptr_t'(rb_dist(32'(wc_d), 32'(rd_d), PTRW));
    pend_d  = rb_ptr_t'(rb_dist(32'(wt_d), 32'(wc_d), PTRW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      wc_q        <= '0;
      wt_q        <= '0;
      used_q      <= '0;
      pend_q      <= '0;
      push_done_q <= 1'b0;
      push_ovf_q  <= 1'b0;
      pop_done_q  <= 1'b0;
      pop_unf_q   <= 1'b0;
      data_vld_q  <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wc_q        <= wc_d;
      wt_q        <= wt_d;
      used_q      <= used_d;
      pend_q      <= pend_d;
      push_done_q <= push_request;
      push_ovf_q  <= push_request && full;
      pop_done_q  <= pop_request;
      pop_unf_q   <= pop_request && empty;
      if (pop_ok) data_vld_q <= 1'b1;
    end
  end

  rb_dpram #(
    .DEPTH (DEPTH),
    .DATAW (DATAW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_ok),
    .waddr_i (wt_base[AW-1:0]),
    .wdata_i (push_data),
    .re_i    (pop_ok),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Storage has no reset, so mask the read register until the first successful pop.
  assign pop_data      = data_vld_q ? ram_rdata : '0;
  assign push_done     = push_done_q;
  assign push_overflow = push_ovf_q;
  assign pop_done      = pop_done_q;
  assign pop_underflow = pop_unf_q;
  assign used_count    = used_q;
  assign pending_count = pend_q;

endmodule

// File: tb/tb_transactional_ring_buffer.sv
// Self-checking bench for transactional_ring_buffer (DEPTH=8, DATAW=16): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_transactional_ring_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DATAW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_request = 1'b0;
  logic [DATAW-1:0] push_data = '0;
  logic             push_done, push_overflow;
  logic             pop_request = 1'b0;
  logic [DATAW-1:0] pop_data;
  logic             pop_done, pop_underflow;
  logic             rb_open = 1'b0, rb_commit = 1'b0, rb_rollback = 1'b0;
  logic [3:0]       used_count, pending_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: committed words and pending words as plain queues.
  logic [DATAW-1:0] m_comm[$];
  logic [DATAW-1:0] m_pend[$];
  logic             e_push_done, e_ovf, e_pop_done, e_unf;
  logic [DATAW-1:0] e_pop_data;
  int               e_used, e_pend;

  always #5 clk = ~clk;

  transactional_ring_buffer #(
    .DEPTH (DEPTH),
    .DATAW (DATAW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_request  (push_request),
    .push_data     (push_data),
    .push_done     (push_done),
    .push_overflow (push_overflow),
    .pop_request   (pop_request),
    .pop_data      (pop_data),
    .pop_done      (pop_done),
    .pop_underflow (pop_underflow),
    .rb_open       (rb_open),
    .rb_commit     (rb_commit),
    .rb_rollback   (rb_rollback),
    .used_count    (used_count),
    .pending_count (pending_count)
  );

  task automatic model_clear();
    m_comm.delete();
    m_pend.delete();
    e_push_done = 1'b0; e_ovf = 1'b0; e_pop_done = 1'b0; e_unf = 1'b0;
    e_pop_data = '0; e_used = 0; e_pend = 0;
  endtask

  // One clock of stimulus; the model is advanced and outputs are ready to sample on return.
  task automatic drive(input logic pu, input logic [DATAW-1:0] d, input logic po,
                       input logic op, input logic cm, input logic rb);
    int  kept;
    logic full;
    @(negedge clk);
    push_request = pu; push_data = d; pop_request = po;
    rb_open = op; rb_commit = cm; rb_rollback = rb;
    @(posedge clk);
    kept = (rb || (!cm && op)) ? 0 : m_pend.size();
    full = (m_comm.size() + kept) >= DEPTH;
    e_push_done = pu;
    e_pop_done  = po;
    e_unf       = po && (m_comm.size() == 0);
    if (po && m_comm.size() != 0) e_pop_data = m_comm.pop_front();
    if (rb) m_pend.delete();
    else if (cm) begin
      while (m_pend.size() != 0) m_comm.push_back(m_pend.pop_front());
    end else if (op) m_pend.delete();
    e_ovf = pu && full;
    if (pu && !full) m_pend.push_back(d);
    e_used = m_comm.size();
    e_pend = m_pend.size();
    #1;
    push_request = 1'b0; pop_request = 1'b0;
    rb_open = 1'b0; rb_commit = 1'b0; rb_rollback = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({push_done, push_overflow, pop_done, pop_underflow} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {push_done, push_overflow, pop_done, pop_underflow});
    end
    n_cmp++;
    if (pop_data !== 16'h0 || used_count !== 4'd0 || pending_count !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_data_counts: got data=%h used=%0d pend=%0d want 0/0/0",
               pop_data, used_count, pending_count);
    end
  endtask

  task automatic test_commit_pop();
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) drive(1, 16'hA000 + 16'(i), 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (used_count !== 4'd3) begin
      n_bad++; $display("FAIL commit_used: got %0d want 3", used_count);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (pop_data !== 16'hA000 + 16'(i) || pop_underflow !== 1'b0 || pop_done !== 1'b1 ||
          used_count !== 4'(3 - i)) begin
        n_bad++;
        $display("FAIL pop_%0d: got data=%h unf=%b done=%b used=%0d want %h/0/1/%0d", i,
                 pop_data, pop_underflow, pop_done, used_count, 16'hA000 + 16'(i), 3 - i);
      end
    end
  endtask

  task automatic test_rollback();
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 16'h1111, 0, 0, 0, 0);
    drive(1, 16'h2222, 0, 0, 0, 0);
    n_cmp++;
    if (pending_count !== 4'd2) begin
      n_bad++; $display("FAIL rb_pending_before: got %0d want 2", pending_count);
    end
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (pop_underflow !== 1'b1 || pop_data !== 16'hA003 || pending_count !== 4'd0 ||
        used_count !== 4'd0) begin
      n_bad++;
      $display("FAIL rb_underflow: got unf=%b data=%h pend=%0d used=%0d want 1/a003/0/0",
               pop_underflow, pop_data, pending_count, used_count);
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) drive(1, 16'(i), 0, 0, 0, 0);
    n_cmp++;
    if (push_done !== 1'b1 || push_overflow !== 1'b1 || pending_count !== 4'd8) begin
      n_bad++;
      $display("FAIL overflow: got done=%b ovf=%b pend=%0d want 1/1/8",
               push_done, push_overflow, pending_count);
    end
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (pop_data !== 16'(i) || pop_underflow !== 1'b0) begin
        n_bad++;
        $display("FAIL ovf_pop_%0d: got %h unf=%b want %h/0", i, pop_data, pop_underflow,
                 16'(i));
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    for (int r = 0; r < 3; r++) begin
      drive(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) drive(1, 16'hB000 + 16'(r * 6 + i), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
        drive(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (pop_data !== 16'hB000 + 16'(n) || pop_underflow !== 1'b0) begin
          n_bad++;
          $display("FAIL wrap_%0d: got %h unf=%b want %h/0", n, pop_data, pop_underflow,
                   16'hB000 + 16'(n));
        end
        n++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [DATAW-1:0] want [3];
    want[0] = 16'h5001; want[1] = 16'h5002; want[2] = 16'hBEEF;
    do_reset();
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 16'h5001, 0, 0, 0, 0);
    drive(1, 16'h5002, 0, 0, 0, 0);
    drive(1, 16'hC0DE, 0, 0, 1, 0);
    n_cmp++;
    if (used_count !== 4'd2 || pending_count !== 4'd1) begin
      n_bad++;
      $display("FAIL push_on_commit: got used=%0d pend=%0d want 2/1", used_count, pending_count);
    end
    drive(1, 16'hBEEF, 0, 0, 0, 1);
    n_cmp++;
    if (pending_count !== 4'd1 || used_count !== 4'd2) begin
      n_bad++;
      $display("FAIL push_on_rollback: got pend=%0d used=%0d want 1/2", pending_count,
               used_count);
    end
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (pop_data !== want[i]) begin
        n_bad++; $display("FAIL sim_pop_%0d: got %h want %h", i, pop_data, want[i]);
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 16'h7777, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (used_count !== 4'd0 || pending_count !== 4'd0) begin
      n_bad++;
      $display("FAIL rollback_beats_commit: got used=%0d pend=%0d want 0/0", used_count,
               pending_count);
    end
  endtask

  task automatic test_random();
    logic pu, po, op, cm, rb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pu = $urandom_range(99) < 60;
      po = $urandom_range(99) < 35;
      op = $urandom_range(99) < 8;
      cm = $urandom_range(99) < 20;
      rb = $urandom_range(99) < 5;
      drive(pu, 16'($urandom), po, op, cm, rb);
      n_cmp++;
      if (push_done !== e_push_done || push_overflow !== e_ovf || pop_done !== e_pop_done ||
          pop_underflow !== e_unf || pop_data !== e_pop_data ||
          used_count !== 4'(e_used) || pending_count !== 4'(e_pend)) begin
        n_bad++;
        $display("FAIL random_c%0d: got pd=%b ov=%b qd=%b uf=%b d=%h u=%0d p=%0d want %b %b %b %b %h %0d %0d",
                 c, push_done, push_overflow, pop_done, pop_underflow, pop_data, used_count,
                 pending_count, e_push_done, e_ovf, e_pop_done, e_unf, e_pop_data, e_used,
                 e_pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 16'hD001, 0, 0, 0, 0);
    drive(1, 16'hD002, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 16'hD003, 0, 0, 0, 0);
    n_cmp++;
    if (used_count !== 4'd2 || pending_count !== 4'd1 || push_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: got used=%0d pend=%0d done=%b want 2/1/1", used_count,
               pending_count, push_done);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (used_count !== 4'd0 || pending_count !== 4'd0 || push_done !== 1'b0 ||
        pop_done !== 1'b0 || push_overflow !== 1'b0 || pop_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got used=%0d pend=%0d flags=%b want 0/0/0000", used_count,
               pending_count, {push_done, push_overflow, pop_done, pop_underflow});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (pop_underflow !== 1'b1 || pop_done !== 1'b1 || pop_data !== 16'h0) begin
      n_bad++;
      $display("FAIL post_reset_pop: got unf=%b done=%b data=%h want 1/1/0000", pop_underflow,
               pop_done, pop_data);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_commit_pop();
    test_rollback();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
